lm_sm_sequencer: RTL and testbench
==================================

# lm_sm_sequencer

Micro-op sequencer for load-multiple (LM) and store-multiple (SM) instructions. It sits beside the decode stage. It watches the IF/ID instruction and, for an LM/SM, emits one single-register micro-op per set bit of the 8-bit register mask on consecutive cycles. While it does so it holds PC and IF/ID, and it flags the first micro-op so the memory stage takes its address from RA rather than from the incremented address.

## Interface
Parameters:
- OP_LM, 4'b0110, opcode of load-multiple
- OP_SM, 4'b0111, opcode of store-multiple

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- id_ir  in  16  IR from IF/ID register; opcode [15:12], RA [11:9], mask [7:0]
- id_valid  in  1  IF/ID holds a valid instruction
- stall_in  in  1  downstream hazard stall; freezes sequencer
- flush  in  1  branch/jump flush of IF/ID; aborts any sequence
- uop_sel  out  1  decode consumes uop_ir instead of id_ir
- uop_valid  out  1  uop_ir is a real micro-op
- uop_ir  out  16  {opcode, RA, 1'b0, one-hot mask of current register}
- reg_idx  out  3  index of current register
- first_multiple  out  1  first micro-op of the instruction
- uop_last  out  1  final micro-op of the instruction
- pc_write  out  1  PC and IF/ID may advance
- busy  out  1  state == SEQ

## Operation
- Mask bit i selects register Ri. Registers are issued in ascending order, R0 first.
- Internal state:
  - FSM with states IDLE and SEQ
  - op_q[3:0], ra_q[2:0], rem_q[7:0] (registers still to issue)
- `multi` = id_valid & (id_ir[15:12]==OP_LM | id_ir[15:12]==OP_SM).
- Source mask src = (state==IDLE) ? id_ir[7:0] : rem_q. Current bit cur = lowest set bit of src (priority encoder). nxt = src & ~onehot(cur).
- IDLE, `multi`, src≠0 (outputs combinational):
  - uop_sel=1, uop_valid=1, first_multiple=1
  - uop_ir={id_ir[15:9],1'b0,onehot(cur)}, reg_idx=cur
  - uop_last=(nxt==0), pc_write=(nxt==0)&~stall_in
  - On edge, if ~stall_in & ~flush & nxt≠0: capture op/RA, rem_q←nxt, go to SEQ.
- IDLE, `multi`, mask==0:
  - Treated as NOP: uop_sel=1, uop_valid=0, pc_write=~stall_in.
  - No state change.
- IDLE, not `multi`: uop_sel=0, uop_valid=0, first_multiple=0, uop_last=0, uop_ir=16'h0000, reg_idx=0, pc_write=~stall_in.
- SEQ:
  - uop_sel=1, uop_valid=1, first_multiple=0
  - uop_ir={op_q,ra_q,1'b0,onehot(cur)}
  - uop_last=(nxt==0), pc_write=(nxt==0)&~stall_in
  - id_ir is ignored; IF/ID is being held.
  - On edge, if ~stall_in: rem_q←nxt, and go to IDLE when nxt==0.
- stall_in=1: no register updates; outputs recompute from the frozen state, so the same micro-op is presented again; pc_write=0.
- flush=1 (priority over stall_in and capture): next state IDLE, rem_q←0. The current-cycle outputs are still driven; decode discards them because of the flush.
- Opcodes other than OP_LM/OP_SM are never captured.

## Timing
- Reset (reset==0 at an edge): state=IDLE, op_q=0, ra_q=0, rem_q=0.
  - With id_valid=0, outputs are uop_sel=0, uop_valid=0, first_multiple=0, uop_last=0, busy=0, uop_ir=0, reg_idx=0, pc_write=1.
  - Reset mid-sequence abandons remaining micro-ops.
- Zero-bubble issue. For a mask with k≥1 set bits and no stall:
  - micro-ops appear in cycles 0..k-1 (cycle 0 = the cycle the instruction sits in IF/ID in IDLE)
  - pc_write=0 in cycles 0..k-2 and 1 in cycle k-1
  - busy=1 in cycles 1..k-1
- k=1: single cycle, first_multiple=uop_last=1, pc_write=1, FSM stays IDLE.
- Each stalled cycle extends the sequence by exactly one cycle with no skipped or duplicated state advance.
- flush asserted in cycle j: micro-ops j+1.. are never issued. The cycle after the flush is IDLE and evaluates the new id_ir.
- Back-to-back LM/SM: after uop_last with pc_write=1, the next instruction is evaluated in IDLE the following cycle.

## Test plan
- Reset, then LM (id_ir=16'h6_6A5: op 0110, RA=R3, mask 8'hA5), no stall:
  - reg_idx sequence 0,2,5,7 over 4 cycles
  - first_multiple only on cycle 0; uop_last only on cycle 3
  - pc_write 0,0,0,1; busy 0,1,1,1
  - uop_ir[7:0]=01,04,20,80
- SM with mask 8'h40 → one cycle: reg_idx=6, first_multiple=1, uop_last=1, pc_write=1, FSM stays IDLE.
- LM with mask 8'h00 → uop_sel=1, uop_valid=0, pc_write=1, busy stays 0.
- Mask 8'h0F with stall_in=1 on cycles 1 and 2:
  - reg_idx 0,1,1,1,2,3
  - pc_write low until the final cycle; no register skipped
- Mask 8'hFF with flush at cycle 3 → busy=0 at cycle 4, no further micro-ops, a following ADD passes with uop_sel=0.
- reset=0 at cycle 2 of mask 8'h33 → all outputs at reset values next cycle; rem_q=0.

Source files
------------

// File: rtl/lm_sm_sequencer.sv
// LM/SM micro-op sequencer: expands a load/store-multiple into one single-register
// micro-op per mask bit, holding PC and IF/ID until the last one issues.
module lm_sm_sequencer #(
    parameter logic [3:0] OP_LM = 4'b0110,
    parameter logic [3:0] OP_SM = 4'b0111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] id_ir,
    input  logic        id_valid,
    input  logic        stall_in,
    input  logic        flush,
    output logic        uop_sel,
    output logic        uop_valid,
    output logic [15:0] uop_ir,
    output logic [2:0]  reg_idx,
    output logic        first_multiple,
    output logic        uop_last,
    output logic        pc_write,
    output logic        busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEQ  = 1'b1;

    logic [0:0] state_q;
    logic [3:0] op_q;
    logic [2:0] ra_q;
    logic [7:0] rem_q;

    logic       multi;
    logic [7:0] src;
    logic [2:0] cur;
    logic [7:0] cur_oh;
    logic [7:0] nxt;

    // Lowest set bit wins, so registers issue R0 first.
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        logic [7:0] oh;
        oh = 8'h00;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign multi  = id_valid & ((id_ir[15:12] == OP_LM) | (id_ir[15:12] == OP_SM));
    assign src    = (state_q == IDLE) ? id_ir[7:0] : rem_q;
    assign cur    = lowest_bit(src);
    assign cur_oh = onehot8(cur);
    assign nxt    = src & ~cur_oh;
    assign busy   = (state_q == SEQ);

    always_comb begin
        uop_sel        = 1'b0;
        uop_valid      = 1'b0;
        uop_ir         = 16'h0000;
        reg_idx        = 3'd0;
        first_multiple = 1'b0;
        uop_last       = 1'b0;
        pc_write       = ~stall_in;
        if (state_q == SEQ) begin
            uop_sel   = 1'b1;
            uop_valid = 1'b1;
            uop_ir    = {op_q, ra_q, 1'b0, cur_oh};
            reg_idx   = cur;
            uop_last  = (nxt == 8'h00);
            pc_write  = (nxt == 8'h00) & ~stall_in;
        end else if (multi) begin
            uop_sel = 1'b1;
            // An empty mask behaves as a NOP that still consumes the slot.
            if (src != 8'h00) begin
                uop_valid      = 1'b1;
                first_multiple = 1'b1;
                uop_ir         = {id_ir[15:9], 1'b0, cur_oh};
                reg_idx        = cur;
                uop_last       = (nxt == 8'h00);
                pc_write       = (nxt == 8'h00) & ~stall_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= 4'd0;
            ra_q    <= 3'd0;
            rem_q   <= 8'h00;
        end else if (flush) begin
            state_q <= IDLE;
            rem_q   <= 8'h00;
        end else if (!stall_in) begin
            case (state_q)
                IDLE: begin
                    // Single-bit masks finish in IDLE and never enter SEQ.
                    if (multi && (src != 8'h00) && (nxt != 8'h00)) begin
                        op_q    <= id_ir[15:12];
                        ra_q    <= id_ir[11:9];
                        rem_q   <= nxt;
                        state_q <= SEQ;
                    end
                end
                SEQ: begin
                    rem_q <= nxt;
                    if (nxt == 8'h00) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rem_q   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer with hand-computed expected micro-op streams.
module tb_lm_sm_sequencer;

    logic        clk;
    logic        reset;
    logic [15:0] id_ir;
    logic        id_valid;
    logic        stall_in;
    logic        flush;
    logic        uop_sel;
    logic        uop_valid;
    logic [15:0] uop_ir;
    logic [2:0]  reg_idx;
    logic        first_multiple;
    logic        uop_last;
    logic        pc_write;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    lm_sm_sequencer #(.OP_LM(4'b0110), .OP_SM(4'b0111)) dut (
        .clk(clk),
        .reset(reset),
        .id_ir(id_ir),
        .id_valid(id_valid),
        .stall_in(stall_in),
        .flush(flush),
        .uop_sel(uop_sel),
        .uop_valid(uop_valid),
        .uop_ir(uop_ir),
        .reg_idx(reg_idx),
        .first_multiple(first_multiple),
        .uop_last(uop_last),
        .pc_write(pc_write),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".uop_sel"},   16'(uop_sel), 16'd0);
        check({tag, ".uop_valid"}, 16'(uop_valid), 16'd0);
        check({tag, ".first"},     16'(first_multiple), 16'd0);
        check({tag, ".last"},      16'(uop_last), 16'd0);
        check({tag, ".busy"},      16'(busy), 16'd0);
        check({tag, ".uop_ir"},    uop_ir, 16'h0000);
        check({tag, ".reg_idx"},   16'(reg_idx), 16'd0);
        check({tag, ".pc_write"},  16'(pc_write), 16'd1);
    endtask

    task automatic check_uop(input string tag, input logic [2:0] e_idx, input logic [15:0] e_ir,
                             input logic e_first, input logic e_last, input logic e_pc,
                             input logic e_busy);
        check({tag, ".uop_sel"},   16'(uop_sel), 16'd1);
        check({tag, ".uop_valid"}, 16'(uop_valid), 16'd1);
        check({tag, ".reg_idx"},   16'(reg_idx), 16'(e_idx));
        check({tag, ".uop_ir"},    uop_ir, e_ir);
        check({tag, ".first"},     16'(first_multiple), 16'(e_first));
        check({tag, ".last"},      16'(uop_last), 16'(e_last));
        check({tag, ".pc_write"},  16'(pc_write), 16'(e_pc));
        check({tag, ".busy"},      16'(busy), 16'(e_busy));
    endtask

    logic [2:0]  a5_idx  [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    logic [15:0] a5_ir   [4] = '{16'h6601, 16'h6604, 16'h6620, 16'h6680};
    logic [2:0]  f_idx   [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3};
    logic        f_stall [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; id_ir = 16'h0000; id_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        check_idle_outputs("reset");
        check("reset.rem_q", 16'(dut.rem_q), 16'h0000);

        // LM R3, mask A5
        next_cycle();
        reset = 1'b1; id_ir = 16'h66A5; id_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check_uop($sformatf("lmA5.c%0d", c), a5_idx[c], a5_ir[c],
                      c == 0, c == 3, c == 3, c != 0);
            next_cycle();
        end

        // SM single bit: one cycle, stays IDLE
        id_ir = 16'h7040;
        settle();
        check_uop("sm40", 3'd6, 16'h7040, 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        id_valid = 1'b0;
        settle();
        check_idle_outputs("sm40.after");

        // LM with empty mask
        next_cycle();
        id_ir = 16'h6200; id_valid = 1'b1;
        settle();
        check("lm00.uop_sel", 16'(uop_sel), 16'd1);
        check("lm00.uop_valid", 16'(uop_valid), 16'd0);
        check("lm00.pc_write", 16'(pc_write), 16'd1);
        check("lm00.busy", 16'(busy), 16'd0);
        next_cycle();
        settle();
        check("lm00.busy_next", 16'(busy), 16'd0);

        // Mask 0F with two stall cycles
        next_cycle();
        id_ir = 16'h600F;
        for (int c = 0; c < 6; c++) begin
            stall_in = f_stall[c];
            settle();
            check($sformatf("stall.c%0d.reg_idx", c), 16'(reg_idx), 16'(f_idx[c]));
            check($sformatf("stall.c%0d.pc_write", c), 16'(pc_write), 16'(c == 5));
            check($sformatf("stall.c%0d.uop_valid", c), 16'(uop_valid), 16'd1);
            check($sformatf("stall.c%0d.last", c), 16'(uop_last), 16'(c == 5));
            next_cycle();
        end
        stall_in = 1'b0;

        // Mask FF flushed at cycle 3
        id_ir = 16'h60FF;
        for (int c = 0; c < 4; c++) begin
            flush = (c == 3);
            settle();
            check($sformatf("flush.c%0d.reg_idx", c), 16'(reg_idx), 16'(c));
            check($sformatf("flush.c%0d.pc_write", c), 16'(pc_write), 16'd0);
            check($sformatf("flush.c%0d.busy", c), 16'(busy), 16'(c != 0));
            next_cycle();
        end
        flush = 1'b0;
        id_ir = 16'h0123;
        for (int c = 4; c < 6; c++) begin
            settle();
            check($sformatf("flush.c%0d.busy", c), 16'(busy), 16'd0);
            check($sformatf("flush.c%0d.uop_sel", c), 16'(uop_sel), 16'd0);
            check($sformatf("flush.c%0d.uop_valid", c), 16'(uop_valid), 16'd0);
            check($sformatf("flush.c%0d.pc_write", c), 16'(pc_write), 16'd1);
            next_cycle();
        end

        // Mask 33 with reset asserted in cycle 2
        id_ir = 16'h6633;
        settle();
        check_uop("rst33.c0", 3'd0, 16'h6601, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        settle();
        check_uop("rst33.c1", 3'd1, 16'h6602, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        reset = 1'b0;
        settle();
        check_uop("rst33.c2", 3'd4, 16'h6610, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        reset = 1'b1; id_valid = 1'b0;
        settle();
        check_idle_outputs("rst33.c3");
        check("rst33.rem_q", 16'(dut.rem_q), 16'h0000);
        next_cycle();
        settle();
        check("rst33.c4.busy", 16'(busy), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
